// File: rtl/pixel_stream_if.sv
// Registered raster pixel stream (valid, position, line/frame framing, frame count)
// carried from a pixel source to its consumer.
interface pixel_stream_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 11
);
  logic [DATA_W-1:0] data;
  logic              dval;
  logic [CNT_W-1:0]  x_cont;
  logic [CNT_W-1:0]  y_cont;
  logic              lval;
  logic              fval;
  logic [15:0]       frame_cont;
  logic              busy;

  modport master (output data, dval, x_cont, y_cont, lval, fval, frame_cont, busy);
  modport slave  (input  data, dval, x_cont, y_cont, lval, fval, frame_cont, busy);
endinterface

// File: rtl/pixel_stream_source.sv
// Synthetic raster pixel source: ramp/constant/checkerboard/x-gradient patterns with
// line and frame blanking, stall support and stop-at-end-of-frame.
module pixel_stream_source #(
  parameter int DATA_W = 12,
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int HBLANK = 16,
  parameter int VBLANK = 4,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              stall,
  input  logic [1:0]        pat_sel,
  input  logic [DATA_W-1:0] seed,
  pixel_stream_if.master    px
);

  localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BLANK_W   = $clog2(BLANK_MAX + 1);
  localparam logic [CNT_W-1:0]   LAST_X  = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0]   LAST_Y  = CNT_W'(ROWS - 1);
  localparam logic [BLANK_W-1:0] HB_LAST = BLANK_W'(HBLANK - 1);
  localparam logic [BLANK_W-1:0] VB_LAST = BLANK_W'(VBLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t             state;
  logic [CNT_W-1:0]   x_q, y_q;
  logic [DATA_W-1:0]  data_q;
  logic               dval_q, lval_q, fval_q, busy_q;
  logic [15:0]        frame_q;
  logic [1:0]         pat_q;
  logic [DATA_W-1:0]  seed_q;
  logic [DATA_W-1:0]  ramp_q;
  logic [BLANK_W-1:0] blank_q;
  logic               stop_pend;
  logic               stop_req;
  logic               frame_begin;

  // ramp_q already holds the raster index of the next pixel, so no multiplier is needed
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] cval,
    input logic [CNT_W-1:0]  px_x,
    input logic [CNT_W-1:0]  px_y,
    input logic [DATA_W-1:0] ramp
  );
    case (sel)
      2'd0:    pattern = ramp;
      2'd1:    pattern = cval;
      2'd2:    pattern = (px_x[0] ^ px_y[0]) ? '1 : '0;
      default: pattern = DATA_W'(px_x);
    endcase
  endfunction

  assign stop_req    = stop_pend | stop;
  assign frame_begin = ((state == S_IDLE) && start) ||
                       ((state == S_VBLANK) && (blank_q == VB_LAST) && !stop_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      data_q    <= '0;
      dval_q    <= 1'b0;
      lval_q    <= 1'b0;
      fval_q    <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= '0;
      pat_q     <= '0;
      seed_q    <= '0;
      ramp_q    <= '0;
      blank_q   <= '0;
      stop_pend <= 1'b0;
    end else begin
      if ((state != S_IDLE) && stop) stop_pend <= 1'b1;

      if (frame_begin) begin
        // Pattern inputs are taken live here and frozen for the rest of the frame
        if (state == S_VBLANK) frame_q <= frame_q + 16'd1;
        state   <= S_ACTIVE;
        pat_q   <= pat_sel;
        seed_q  <= seed;
        x_q     <= '0;
        y_q     <= '0;
        data_q  <= pattern(pat_sel, seed, '0, '0, '0);
        ramp_q  <= DATA_W'(1);
        blank_q <= '0;
        dval_q  <= 1'b1;
        lval_q  <= 1'b1;
        fval_q  <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          S_ACTIVE: begin
            if (stall) begin
              dval_q <= 1'b0;
            end else if (x_q == LAST_X) begin
              state   <= S_HBLANK;
              dval_q  <= 1'b0;
              lval_q  <= 1'b0;
              blank_q <= '0;
            end else begin
              x_q    <= x_q + 1'b1;
              data_q <= pattern(pat_q, seed_q, x_q + 1'b1, y_q, ramp_q);
              ramp_q <= ramp_q + 1'b1;
              dval_q <= 1'b1;
            end
          end
          S_HBLANK: begin
            if (blank_q == HB_LAST) begin
              blank_q <= '0;
              if (y_q == LAST_Y) begin
                state  <= S_VBLANK;
                fval_q <= 1'b0;
              end else begin
                state  <= S_ACTIVE;
                x_q    <= '0;
                y_q    <= y_q + 1'b1;
                data_q <= pattern(pat_q, seed_q, '0, y_q + 1'b1, ramp_q);
                ramp_q <= ramp_q + 1'b1;
                dval_q <= 1'b1;
                lval_q <= 1'b1;
              end
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          S_VBLANK: begin
            // Only the stop exit reaches here; the continue exit is taken by frame_begin
            if (blank_q == VB_LAST) begin
              state     <= S_IDLE;
              frame_q   <= frame_q + 16'd1;
              stop_pend <= 1'b0;
              x_q       <= '0;
              y_q       <= '0;
              data_q    <= '0;
              blank_q   <= '0;
              busy_q    <= 1'b0;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign px.data       = data_q;
  assign px.dval       = dval_q;
  assign px.x_cont     = x_q;
  assign px.y_cont     = y_q;
  assign px.lval       = lval_q;
  assign px.fval       = fval_q;
  assign px.frame_cont = frame_q;
  assign px.busy       = busy_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: small 4x4 raster, directed frames plus random stalls and
// patterns, each pixel checked against a raster-order reference model.
module tb_pixel_stream_source;

  localparam int DATA_W = 12;
  localparam int COLS   = 4;
  localparam int ROWS   = 4;
  localparam int HBLANK = 2;
  localparam int VBLANK = 3;
  localparam int CNT_W  = 11;
  localparam int LINE   = COLS + HBLANK;

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              start   = 1'b0;
  logic              stop    = 1'b0;
  logic              stall   = 1'b0;
  logic [1:0]        pat_sel = 2'd0;
  logic [DATA_W-1:0] seed    = '0;

  int checks_total  = 0;
  int checks_passed = 0;
  int frames_done   = 0;

  pixel_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) px ();

  pixel_stream_source #(
    .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stall(stall),
    .pat_sel(pat_sel), .seed(seed), .px(px)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference pixel value straight from the pattern definitions
  function automatic logic [DATA_W-1:0] modelPixel(input logic [1:0] pat, input logic [DATA_W-1:0] sd,
                                                   input int x, input int y);
    case (pat)
      2'd0:    return DATA_W'((y * COLS + x) % 4096);
      2'd1:    return sd;
      2'd2:    return (((x + y) % 2) == 1) ? 12'hFFF : 12'h000;
      default: return DATA_W'(x % 4096);
    endcase
  endfunction

  function automatic logic [53:0] outWord();
    return {px.frame_cont, px.busy, px.fval, px.lval, px.dval, px.y_cont, px.x_cont, px.data};
  endfunction

  // mode: 0 plain, 2 stop pulse at (0,1), 3 three-cycle stall at (1,2), 4 async reset at (2,3)
  task automatic applyStimulus(input string name, input logic [1:0] pat, input logic [DATA_W-1:0] sd,
                               input logic [1:0] next_pat, input logic [DATA_W-1:0] next_sd,
                               input int stall_pct, input int mode);
    int pix = 0;
    int cyc = 0;
    int held = 0;
    int forced = 0;
    bit aborted = 1'b0;
    logic [33:0] last_word = '0;
    checkOutput({name, " frame_cont"}, 64'(px.frame_cont), 64'(frames_done));
    while (pix < COLS * ROWS && cyc < 400 && !aborted) begin
      int ex;
      int ey;
      ex = pix % COLS;
      ey = pix / COLS;
      stall = 1'b0;
      stop  = 1'b0;
      if (px.dval) begin
        last_word = {px.y_cont, px.x_cont, px.data};
        checkOutput({name, " pixel"},
                    64'({px.y_cont, px.x_cont, px.data, px.lval, px.fval, px.busy}),
                    64'({CNT_W'(ey), CNT_W'(ex), modelPixel(pat, sd, ex, ey), 3'b111}));
        checkOutput({name, " timing"}, 64'(cyc), 64'(ey * LINE + ex + held));
        if (mode == 3 && ex == 1 && ey == 2) forced = 3;
        if (mode == 2 && ex == 0 && ey == 1) stop = 1'b1;
        if (pix == 5) begin
          pat_sel = next_pat;
          seed    = next_sd;
        end
        if (mode == 4 && ex == 2 && ey == 3) begin
          #2 rst = 1'b1;
          #1;
          checkOutput({name, " async reset"}, 64'(outWord()), 64'(0));
          aborted = 1'b1;
        end
        pix++;
      end else if (px.lval) begin
        held++;
        checkOutput({name, " stall hold"}, 64'({px.y_cont, px.x_cont, px.data}), 64'(last_word));
      end else begin
        checkOutput({name, " hblank"}, 64'({px.x_cont, px.fval, px.busy}),
                    64'({CNT_W'(COLS - 1), 2'b11}));
      end
      if (pix < COLS * ROWS && !aborted) begin
        if (forced > 0) begin
          stall = 1'b1;
          forced--;
        end else if (stall_pct > 0) begin
          stall = ($urandom_range(99) < stall_pct);
        end
        tick();
        cyc++;
      end
    end
    if (!aborted) checkOutput({name, " pixel count"}, 64'(pix), 64'(COLS * ROWS));
    if (mode == 3) checkOutput({name, " stall cycles"}, 64'(held), 64'(3));
  endtask

  task automatic waitGap(input string name, input bit expect_stop);
    int cyc = 0;
    int vlow = 0;
    stall = 1'b0;
    stop  = 1'b0;
    do begin
      tick();
      cyc++;
      if (px.busy && !px.fval) vlow++;
    end while (!px.dval && px.busy && cyc < 100);
    frames_done++;
    checkOutput({name, " gap"}, 64'(cyc), 64'(HBLANK + VBLANK + 1));
    checkOutput({name, " vblank"}, 64'(vlow), 64'(VBLANK));
    if (expect_stop)
      checkOutput({name, " stopped"}, 64'(outWord() >> DATA_W), 64'({16'(frames_done), 4'b0000, 22'd0}));
    else
      checkOutput({name, " restart"}, 64'({px.dval, px.busy, px.x_cont, px.y_cont}), 64'({2'b11, 22'd0}));
  endtask

  initial begin
    logic [1:0]        rp;
    logic [DATA_W-1:0] rs;
    $display("[TB] pixel_stream_source bench, %0dx%0d raster", COLS, ROWS);

    repeat (2) tick();
    checkOutput("reset state", 64'(outWord()), 64'(0));
    rst = 1'b0;
    tick();
    checkOutput("idle after reset", 64'(outWord()), 64'(0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    checkOutput("idle ignores stop", 64'({px.busy, px.dval}), 64'(0));

    pat_sel = 2'd0;
    seed    = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    applyStimulus("f0 ramp", 2'd0, '0, 2'd0, '0, 0, 0);
    waitGap("f0", 1'b0);
    applyStimulus("f1 ramp", 2'd0, '0, 2'd2, '0, 0, 0);
    waitGap("f1", 1'b0);
    applyStimulus("f2 checker", 2'd2, '0, 2'd1, 12'hABC, 0, 0);
    waitGap("f2", 1'b0);
    applyStimulus("f3 const", 2'd1, 12'hABC, 2'd0, '0, 0, 0);
    waitGap("f3", 1'b0);
    applyStimulus("f4 ramp stall", 2'd0, '0, 2'd3, '0, 0, 3);
    waitGap("f4", 1'b0);
    rp = 2'($urandom_range(3));
    rs = DATA_W'($urandom);
    applyStimulus("f5 xgrad rnd stall", 2'd3, '0, rp, rs, 40, 0);
    waitGap("f5", 1'b0);
    applyStimulus("f6 rnd stop", rp, rs, rp, rs, 25, 2);
    waitGap("f6", 1'b1);
    repeat (4) tick();
    checkOutput("idle after stop", 64'({px.busy, px.dval, px.frame_cont}), 64'({2'b00, 16'd7}));

    rp      = 2'($urandom_range(3));
    rs      = DATA_W'($urandom);
    pat_sel = rp;
    seed    = rs;
    start   = 1'b1;
    stop    = 1'b1;
    tick();
    start   = 1'b0;
    stop    = 1'b0;
    applyStimulus("f7 start+stop", rp, rs, 2'd0, '0, 0, 0);
    waitGap("f7", 1'b0);
    applyStimulus("f8 reset", 2'd0, '0, 2'd0, '0, 0, 4);
    repeat (2) tick();
    rst = 1'b0;
    frames_done = 0;
    repeat (3) tick();
    checkOutput("idle after mid-frame reset", 64'(outWord()), 64'(0));

    pat_sel = 2'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    applyStimulus("f9 ramp stop", 2'd0, '0, 2'd0, '0, 0, 2);
    waitGap("f9", 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
